// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings, FSM states and width defaults for the multi-cycle shifter
package shift_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_UPR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/shift_unit_mc_if.sv
// rtl/shift_unit_mc_if.sv - request/result handshake bundle for shift_unit_mc
interface shift_unit_mc_if
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    localparam int SW = $clog2(XLEN);

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_a;
    logic [SW-1:0]   in_shamt;
    logic [1:0]      in_typ;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_r;
    logic            busy;

    modport master (
        output in_valid, in_a, in_shamt, in_typ, flush, out_ready,
        input  in_ready, out_valid, out_r, busy
    );

    modport slave (
        input  in_valid, in_a, in_shamt, in_typ, flush, out_ready,
        output in_ready, out_valid, out_r, busy
    );
endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational single-iteration shifter; SHIFT_MC_ROTATE_EN turns typ 11 into ROR
module shift_step
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int SW   = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] value,
    input  logic [SW-1:0]   step,
    input  logic [1:0]      typ,
    input  logic            sign,
    output logic [XLEN-1:0] result
);
`ifdef SHIFT_MC_ROTATE_EN
    localparam logic [SW:0] XL = XLEN[SW:0];
    logic [SW:0] wrap_amt;
    assign wrap_amt = XL - {1'b0, step};
`endif

    always_comb begin
        result = value;
        case (typ)
            SH_SLL: result = value << step;
            SH_SRL: result = value >> step;
            // Fill from the operand's original sign bit latched at accept time
            SH_SRA: result = (value >> step) | (sign ? ~({XLEN{1'b1}} >> step) : '0);
            SH_UPR: begin
`ifdef SHIFT_MC_ROTATE_EN
                result = (value >> step) | (value << wrap_amt);
`else
                result = value;
`endif
            end
            default: result = value;
        endcase
    end
endmodule

// File: rtl/shift_unit_mc.sv
// rtl/shift_unit_mc.sv - iterative STEP-bits-per-cycle shifter with valid/ready result; honours SHIFT_MC_ROTATE_EN
module shift_unit_mc
    import shift_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    shift_unit_mc_if.slave  bus
);
    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] STEP_C = SW'(STEP);

    state_t          state, state_next;
    logic [XLEN-1:0] r;
    logic [SW-1:0]   rem;
    logic [1:0]      typ_q;
    logic            sign_q;
    logic            accept;
    logic            direct;
    logic [XLEN-1:0] load_val;
    logic [SW-1:0]   step_amt;
    logic [SW-1:0]   rem_next;
    logic [XLEN-1:0] step_res;

    assign step_amt = (rem < STEP_C) ? rem : STEP_C;
    assign rem_next = rem - step_amt;

`ifdef SHIFT_MC_ROTATE_EN
    assign direct   = (bus.in_shamt == '0);
    assign load_val = bus.in_a;
`else
    assign direct   = (bus.in_typ == SH_UPR) || (bus.in_shamt == '0);
    assign load_val = (bus.in_typ == SH_UPR)
                    ? {{(XLEN/2){1'b0}}, bus.in_a[XLEN-1:XLEN/2]}
                    : bus.in_a;
`endif

    shift_step #(.XLEN(XLEN), .SW(SW)) u_step (
        .value  (r),
        .step   (step_amt),
        .typ    (typ_q),
        .sign   (sign_q),
        .result (step_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        bus.in_ready  = (state == ST_IDLE);
        bus.out_valid = (state == ST_DONE);
        bus.busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = direct ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (rem_next == '0) state_next = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
        // Kill wins over both acceptance and completion
        if (bus.flush) begin
            accept     = 1'b0;
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r      <= '0;
            rem    <= '0;
            typ_q  <= SH_SLL;
            sign_q <= 1'b0;
        end else if (accept) begin
            r      <= load_val;
            rem    <= bus.in_shamt;
            typ_q  <= bus.in_typ;
            sign_q <= bus.in_a[XLEN-1];
        end else if (state == ST_SHIFT && !bus.flush) begin
            r   <= step_res;
            rem <= rem_next;
        end
    end

    assign bus.out_r = r;

endmodule

// File: tb/tb_shift_unit_mc.sv
// tb/tb_shift_unit_mc.sv - randomized self-checking bench for shift_unit_mc against an arithmetic reference model
module tb_shift_unit_mc;
    import shift_pkg::*;

    localparam int XLEN = 32;
    localparam int STEP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shift_unit_mc_if #(.XLEN(XLEN)) bus ();

    shift_unit_mc #(.XLEN(XLEN), .STEP(STEP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] typ);
        logic signed [31:0] s;
        logic [63:0] d;
        s = a;
        d = {a, a} >> sh;
        case (typ)
            2'b00: return a << sh;
            2'b01: return a >> sh;
            2'b10: return s >>> sh;
            default: begin
`ifdef SHIFT_MC_ROTATE_EN
                return d[31:0];
`else
                return {16'h0000, a[31:16]};
`endif
            end
        endcase
    endfunction

    function automatic int ref_latency(input logic [4:0] sh, input logic [1:0] typ);
        if (sh == 0) return 1;
`ifndef SHIFT_MC_ROTATE_EN
        if (typ == 2'b11) return 1;
`endif
        return (int'(sh) + STEP - 1) / STEP + 1;
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] typ,
                          input int hold, input string tag);
        logic [31:0] exp_r;
        int exp_lat;
        int lat;
        exp_r   = ref_result(a, sh, typ);
        exp_lat = ref_latency(sh, typ);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_shamt = sh;
        bus.in_typ   = typ;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 200) begin
            vectors++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                miscompares++;
                $display("FAIL %s busy-phase: in_ready=%b busy=%b want 0/1", tag, bus.in_ready, bus.busy);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        vectors++;
        if (bus.out_valid !== 1'b1 || lat != exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d (out_valid=%b) want %0d", tag, lat, bus.out_valid, exp_lat);
        end
        vectors++;
        if (bus.out_r !== exp_r) begin
            miscompares++;
            $display("FAIL %s result: got %h want %h (a=%h sh=%0d typ=%b)", tag, bus.out_r, exp_r, a, sh, typ);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.out_r !== exp_r || bus.in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s hold: out_valid=%b out_r=%h in_ready=%b want 1/%h/0",
                         tag, bus.out_valid, bus.out_r, bus.in_ready, exp_r);
            end
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     tag, bus.out_valid, bus.in_ready, bus.busy);
        end
    endtask

    task automatic test_reset();
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_r !== 32'h0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_r=%h busy=%b want 1/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_r, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b busy=%b want 1/0/0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_directed();
        run_op(32'h0000_0001, 5'd31, 2'b00, 0, "sll31");
        run_op(32'h8000_0000, 5'd7,  2'b10, 0, "sra7");
        run_op(32'hDEAD_BEEF, 5'd8,  2'b11, 0, "upr8");
        run_op(32'hDEAD_BEEF, 5'd0,  2'b11, 0, "upr0");
        run_op(32'h8765_4321, 5'd4,  2'b01, 0, "srl_exact_step");
    endtask

    task automatic test_stall();
        run_op(32'h1234_5678, 5'd0, 2'b01, 5, "stall_sh0");
        run_op(32'hF0F0_0F0F, 5'd13, 2'b10, 3, "stall_sra");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            run_op($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                   $urandom_range(0, 2), "random");
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'hCAFE_F00D;
        bus.in_shamt = 5'd20;
        bus.in_typ   = 2'b01;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_shift: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     bus.out_valid, bus.in_ready, bus.busy);
        end
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flush_no_result: out_valid=%b want 0", bus.out_valid);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.flush    = 1'b1;
        bus.in_shamt = 5'd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_idle_reject: busy=%b in_ready=%b want 0/1", bus.busy, bus.in_ready);
        end
        run_op(32'h0000_00F0, 5'd9, 2'b00, 0, "after_flush");
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_shamt = 5'd0;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_done: out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h0000_0003;
        bus.in_shamt = 5'd28;
        bus.in_typ   = 2'b00;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_r !== 32'h0 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b out_r=%h busy=%b want 1/0/0/0",
                     bus.in_ready, bus.out_valid, bus.out_r, bus.busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0001, 5'd4, 2'b00, 0, "post_reset_sll");
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_shamt  = '0;
        bus.in_typ    = 2'b00;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/shift_unit_mc.md
Name: shift_unit_mc

Overview:
Multi-cycle sequential shift unit for the execute stage. It is the iterative counterpart of the single-cycle combinational shifter, for area-reduced cores and the M-extension datapath. Each accepted request is shifted STEP bits per cycle, and the result is returned over a valid/ready handshake. It supports the same operation encoding as the combinational shifter, so decode drives both identically.

Parameters:
XLEN, 32, datapath width; fixed power of two, 32 or 64.
STEP, 1, bits shifted per iteration; power of two, 1..XLEN/2.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
in_a  in  XLEN  operand
in_shamt  in  $clog2(XLEN)  shift amount
in_typ  in  2  00 SLL, 01 SRL, 10 SRA, 11 upper-half move
flush  in  1  pipeline kill; abort any in-flight operation
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_r  out  XLEN  result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=1; out_valid=0; out_r=0; busy=0; internal count=0.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&in_ready&!flush, latch a/shamt/typ.
  - If typ==11 or shamt==0, go to DONE; load out_r with the final result (upper-half move: {XLEN/2 zeros, a[XLEN-1:XLEN/2]}; shamt 0: out_r=a).
  - Otherwise go to SHIFT with remaining=shamt.
- SHIFT: each cycle step=min(STEP, remaining). Apply SLL/SRL/SRA by step; SRA replicates the latched bit XLEN-1. Decrement remaining by step. When remaining reaches 0 after the update, go to DONE.
- DONE: out_valid=1. out_r is stable and unchanged until the handshake. On out_ready, go to IDLE with out_valid=0 the next cycle.
- Latency from accept to out_valid: 1 cycle for shamt==0 or typ==11; otherwise ceil(shamt/STEP)+1 cycles. Max XLEN/STEP+1.
- No back-to-back acceptance: in_ready=0 in SHIFT and DONE. A new request is accepted no earlier than the cycle after the out handshake.
- flush: synchronous, highest priority. From any state, go to IDLE next cycle with out_valid=0.
  - flush together with in_valid in IDLE: the request is not accepted.
  - flush together with out_ready in DONE: the result is treated as discarded; no error.
- out_r is don't-care-stable outside DONE but must not glitch-change while out_valid=1.
- Reset asserted mid-operation aborts immediately. The first post-reset request behaves normally.
- in_shamt bits beyond the XLEN range do not exist; the port width bounds the amount.

Optional Feature:
Macro SHIFT_MC_ROTATE_EN.
- Defined: typ 11 means rotate right (ROR) by shamt, iterated exactly like SRL but with wrap-around of the low bits into the top; shamt==0 gives a 1-cycle pass-through.
- Undefined: typ 11 is the 1-cycle upper-half move described above.

Decomposition:
- Shared package shift_pkg holds:
  - typ encodings: SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_UPR=2'b11;
  - state enum {ST_IDLE, ST_SHIFT, ST_DONE};
  - XLEN default constant.
- One natural sub-module, shift_step: combinational single-step shifter taking value, step, and typ. It is reused by the FSM each iteration, keeping the top level to control only.

Test Plan:
- STEP=1, a=0x0000_0001, typ=00, shamt=31, out_ready=1 -> out_valid on cycle 32 after accept, out_r=0x8000_0000, in_ready low throughout.
- STEP=4, a=0x8000_0000, typ=10, shamt=7 -> 2 SHIFT cycles (4+3), out_valid at cycle 3, out_r=0xFF00_0000.
- a=0xDEAD_BEEF, typ=11 (macro off) -> out_valid next cycle, out_r=0x0000_DEAD; with SHIFT_MC_ROTATE_EN, shamt=8 -> out_r=0xEFDE_ADBE.
- STEP=1, a=0x1234_5678, typ=01, shamt=0 -> 1-cycle result 0x1234_5678; then hold out_ready=0 for 5 cycles -> out_valid and out_r stable, in_ready=0.
- Start SRL shamt=20, assert flush on SHIFT cycle 3 -> IDLE next cycle, out_valid never rises. A new request accepted on the following cycle completes correctly.
- Assert rst_n=0 asynchronously mid-SHIFT -> outputs return to reset values without a clock edge. A post-reset SLL of 0x1 by 4 -> 0x10.
